// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - four-digit multiplexed seven-segment driver with anti-ghost blanking
// Snapshots the BCD digits once per frame and blinks the selected field in adjust mode.
module seg7_scan_driver #(
  parameter int GHOST_CYCLES = 4,
  parameter int DP_DIGIT     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] mt,
  input  logic [3:0] mo,
  input  logic [3:0] st,
  input  logic [3:0] so,
  input  logic       tick_fast,
  input  logic       tick_blink,
  input  logic       adj_mode,
  input  logic       sel,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  typedef enum logic {BLANK, DRIVE} state_t;

  localparam logic [7:0] GHOST_LAST = 8'(GHOST_CYCLES - 1);
  localparam logic [1:0] DP_IDX     = 2'(DP_DIGIT);

  state_t      state;
  logic [1:0]  idx;
  logic [7:0]  blank_cnt;
  logic        blink_phase;
  logic [15:0] snapshot;

  logic [15:0] snap_next;
  logic [3:0]  digit;
  logic [6:0]  digit_seg;
  logic        field_off;
  logic [3:0]  drive_an;
  logic [6:0]  drive_seg;
  logic        drive_dp;

  // The idx-0 entry edge decodes the value being captured on that same edge.
  always_comb begin
    snap_next = snapshot;
    if (state == BLANK && idx == 2'd0)
      snap_next = {mt, mo, st, so};
  end

  always_comb begin
    digit = 4'd0;
    case (idx)
      2'd0: digit = snap_next[3:0];
      2'd1: digit = snap_next[7:4];
      2'd2: digit = snap_next[11:8];
      2'd3: digit = snap_next[15:12];
      default: digit = 4'd0;
    endcase
  end

  always_comb begin
    digit_seg = 7'b0111111;
    case (digit)
      4'd0: digit_seg = 7'b1000000;
      4'd1: digit_seg = 7'b1111001;
      4'd2: digit_seg = 7'b0100100;
      4'd3: digit_seg = 7'b0110000;
      4'd4: digit_seg = 7'b0011001;
      4'd5: digit_seg = 7'b0010010;
      4'd6: digit_seg = 7'b0000010;
      4'd7: digit_seg = 7'b1111000;
      4'd8: digit_seg = 7'b0000000;
      4'd9: digit_seg = 7'b0010000;
      default: digit_seg = 7'b0111111;
    endcase
  end

  // sel=1 owns idx 0/1 (seconds), sel=0 owns idx 2/3 (minutes).
  always_comb begin
    field_off = adj_mode & blink_phase & (idx[1] != sel);
    drive_an  = field_off ? 4'b1111 : ~(4'b0001 << idx);
    drive_seg = field_off ? 7'b1111111 : digit_seg;
    drive_dp  = (idx == DP_IDX) ? 1'b0 : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BLANK;
      idx         <= 2'd0;
      blank_cnt   <= 8'd0;
      blink_phase <= 1'b0;
      snapshot    <= 16'd0;
      an          <= 4'b1111;
      seg         <= 7'b1111111;
      dp          <= 1'b1;
    end else begin
      if (!adj_mode)
        blink_phase <= 1'b0;
      else if (tick_blink)
        blink_phase <= ~blink_phase;

      case (state)
        BLANK: begin
          if (blank_cnt == GHOST_LAST) begin
            state     <= DRIVE;
            blank_cnt <= 8'd0;
            snapshot  <= snap_next;
            an        <= drive_an;
            seg       <= drive_seg;
            dp        <= drive_dp;
          end else begin
            blank_cnt <= blank_cnt + 8'd1;
            an        <= 4'b1111;
            seg       <= 7'b1111111;
            dp        <= 1'b1;
          end
        end
        DRIVE: begin
          if (tick_fast) begin
            state <= BLANK;
            idx   <= idx + 2'd1;
            an    <= 4'b1111;
            seg   <= 7'b1111111;
            dp    <= 1'b1;
          end else begin
            an  <= drive_an;
            seg <= drive_seg;
            dp  <= drive_dp;
          end
        end
        default: state <= BLANK;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] mt = 4'd1, mo = 4'd2, st = 4'd3, so = 4'd4;
  logic       tick_fast = 1'b0, tick_blink = 1'b0, adj_mode = 1'b0, sel = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [6:0] S_OFF = 7'b1111111;
  localparam logic [6:0] S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000, S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000;
  localparam logic [6:0] S_DASH = 7'b0111111;

  seg7_scan_driver #(.GHOST_CYCLES(4), .DP_DIGIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .mt(mt), .mo(mo), .st(st), .so(so),
    .tick_fast(tick_fast), .tick_blink(tick_blink), .adj_mode(adj_mode), .sel(sel),
    .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                         input logic e_dp);
    chk({tag, ".an"}, {12'd0, an}, {12'd0, e_an});
    chk({tag, ".seg"}, {9'd0, seg}, {9'd0, e_seg});
    chk({tag, ".dp"}, {15'd0, dp}, {15'd0, e_dp});
  endtask

  // Dwell in DRIVE, strobe tick_fast, verify the 4-clock gap, then the new digit.
  task automatic next_digit(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                            input logic e_dp, input bit tick_in_blank);
    repeat (5) @(negedge clk);
    tick_fast = 1'b1;
    @(negedge clk);
    tick_fast = tick_in_blank;
    chk_out({tag, ".gap0"}, 4'b1111, S_OFF, 1'b1);
    repeat (2) @(negedge clk);
    tick_fast = 1'b0;
    @(negedge clk);
    chk_out({tag, ".gap3"}, 4'b1111, S_OFF, 1'b1);
    @(negedge clk);
    chk_out(tag, e_an, e_seg, e_dp);
  endtask

  task automatic release_reset(input string tag, input logic [6:0] e_seg);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_out({tag, ".pre"}, 4'b1111, S_OFF, 1'b1);
    @(negedge clk);
    chk_out(tag, 4'b1110, e_seg, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_out("reset", 4'b1111, S_OFF, 1'b1);
    release_reset("first", S4);

    next_digit("scan1", 4'b1101, S3, 1'b1, 1'b0);
    next_digit("scan2", 4'b1011, S2, 1'b0, 1'b0);
    next_digit("scan3", 4'b0111, S1, 1'b1, 1'b0);
    next_digit("scan0", 4'b1110, S4, 1'b1, 1'b0);

    next_digit("tear1", 4'b1101, S3, 1'b1, 1'b0);
    next_digit("tear2", 4'b1011, S2, 1'b0, 1'b0);
    {mt, mo, st, so} = {4'd5, 4'd6, 4'd7, 4'd8};
    @(negedge clk);
    chk_out("tear2_hold", 4'b1011, S2, 1'b0);
    next_digit("tear3", 4'b0111, S1, 1'b1, 1'b0);
    next_digit("new0", 4'b1110, S8, 1'b1, 1'b0);
    next_digit("new1", 4'b1101, S7, 1'b1, 1'b0);
    next_digit("new2", 4'b1011, S6, 1'b0, 1'b0);
    next_digit("new3", 4'b0111, S5, 1'b1, 1'b0);

    so = 4'hC;
    next_digit("dash0", 4'b1110, S_DASH, 1'b1, 1'b1);
    so = 4'd8;

    adj_mode = 1'b1;
    sel = 1'b1;
    tick_blink = 1'b1;
    @(negedge clk);
    tick_blink = 1'b0;
    chk_out("blink_edge", 4'b1110, S_DASH, 1'b1);
    @(negedge clk);
    chk_out("blink_off0", 4'b1111, S_OFF, 1'b1);
    next_digit("blink_off1", 4'b1111, S_OFF, 1'b1, 1'b0);
    next_digit("blink_min2", 4'b1011, S6, 1'b0, 1'b0);
    next_digit("blink_min3", 4'b0111, S5, 1'b1, 1'b0);
    next_digit("blink_off0b", 4'b1111, S_OFF, 1'b1, 1'b0);
    adj_mode = 1'b0;
    @(negedge clk);
    chk_out("unblink0", 4'b1110, S8, 1'b1);
    chk("blink_phase", {15'd0, dut.blink_phase}, 16'd0);

    next_digit("mid1", 4'b1101, S7, 1'b1, 1'b0);
    next_digit("mid2", 4'b1011, S6, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 4'b1111, S_OFF, 1'b1);
    @(negedge clk);
    chk_out("rst_hold", 4'b1111, S_OFF, 1'b1);
    release_reset("restart", S8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
